ram_dp: RTL and testbench

RAM_DP -- requirements
Module: ram_dp

---
 rtl/ram_dp.sv | 127 ++++++++++++
 tb/tb_ram_dp.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp.sv
// Simple dual-port RAM with byte enables, a power-up clear sequence,
// selectable read-during-write behaviour and an optional output register.
module ram_dp #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int RDW_NEW    = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    init_busy
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t state, state_next;
  logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_next;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic ready;
  logic wr_in_range, rd_in_range;
  logic wr_fire, rd_accept;
  logic [IDX_W-1:0] wr_idx, rd_idx, clr_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] s1_data;
  logic s1_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    if (state == CLEAR) begin
      if (clr_cnt == LAST_ADDR) state_next = READY;
      else clr_cnt_next = clr_cnt + 1'b1;
    end
  end

  assign ready       = (state == READY);
  assign init_busy   = (state == CLEAR);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
  assign wr_idx      = wr_addr[IDX_W-1:0];
  assign rd_idx      = rd_addr[IDX_W-1:0];
  assign clr_idx     = clr_cnt[IDX_W-1:0];
  assign wr_fire     = ready && wr_en && wr_in_range;
  assign rd_accept   = ready && rd_en;

  // Storage has no reset; it is zeroed only by walking the clear counter.
  always_ff @(posedge clk) begin
    if (!rst && !ready) begin
      mem[clr_idx] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[rd_idx];
      if (RDW_NEW != 0 && wr_fire && wr_addr == rd_addr) begin
        for (int i = 0; i < NB; i++) begin
          if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_accept;
      if (rd_accept) s1_data <= rd_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] s2_data;
      logic s2_valid;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) s2_data <= s1_data;
        end
      end

      assign rd_data  = s2_data;
      assign rd_valid = s2_valid;
    end else begin : g_no_out_reg
      assign rd_data  = s1_data;
      assign rd_valid = s1_valid;
    end
  endgenerate

endmodule

// File: tb/tb_ram_dp.sv
// Bench for ram_dp: two instances (full-depth/old-data/no out reg and
// short-depth/new-data/out reg) driven in lockstep against an array model.
module tb_ram_dp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wr_en, rd_en;
  logic [7:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic [15:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b, init_busy_a, init_busy_b;

  ram_dp #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(256), .RDW_NEW(0), .OUT_REG(0)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a), .init_busy(init_busy_a)
  );

  ram_dp #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(200), .RDW_NEW(1), .OUT_REG(1)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b), .init_busy(init_busy_b)
  );

  int tests_run = 0;
  int fails = 0;
  int cyc = 0;

  int depth_m [2] = '{256, 200};
  int lat_m [2] = '{1, 2};
  bit rdw_m [2] = '{1'b0, 1'b1};
  logic [15:0] mem_m [2][256];
  int clr_left [2];
  bit exp_v [2][2];
  logic [15:0] exp_dat [2][2];
  logic [15:0] exp_hold [2];

  function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = old_w;
    for (int i = 0; i < 2; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  function automatic logic [15:0] dut_data(input int d);
    return (d == 1) ? rd_data_b : rd_data_a;
  endfunction

  function automatic logic dut_valid(input int d);
    return (d == 1) ? rd_valid_b : rd_valid_a;
  endfunction

  function automatic logic dut_busy(input int d);
    return (d == 1) ? init_busy_b : init_busy_a;
  endfunction

  function automatic logic [7:0] rand_addr();
    case ($urandom_range(0, 3))
      0: return 8'($urandom_range(0, 7));
      1: return 8'($urandom_range(195, 205));
      2: return 8'($urandom_range(250, 255));
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      clr_left[d] = depth_m[d];
      exp_hold[d] = '0;
      for (int k = 0; k < 2; k++) begin
        exp_v[d][k]   = 1'b0;
        exp_dat[d][k] = '0;
      end
      for (int a = 0; a < 256; a++) mem_m[d][a] = '0;
    end
  endtask

  // One clock edge; the model consumes the inputs that were stable across it.
  task automatic tick();
    logic [15:0] rv;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      exp_v[d][0]   = exp_v[d][1];
      exp_dat[d][0] = exp_dat[d][1];
      exp_v[d][1]   = 1'b0;
      if (clr_left[d] > 0) begin
        clr_left[d]--;
      end else begin
        if (rd_en) begin
          if (int'(rd_addr) >= depth_m[d]) rv = '0;
          else begin
            rv = mem_m[d][rd_addr];
            if (rdw_m[d] && wr_en && wr_addr == rd_addr) rv = merge(rv, wr_data, wr_be);
          end
          exp_v[d][lat_m[d]-1]   = 1'b1;
          exp_dat[d][lat_m[d]-1] = rv;
        end
        if (wr_en && int'(wr_addr) < depth_m[d])
          mem_m[d][wr_addr] = merge(mem_m[d][wr_addr], wr_data, wr_be);
      end
      if (exp_v[d][0]) exp_hold[d] = exp_dat[d][0];
    end
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic set_write(input logic [7:0] a, input logic [15:0] v, input logic [1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = v; wr_be = be;
  endtask

  task automatic set_read(input logic [7:0] a);
    rd_en = 1'b1; rd_addr = a;
  endtask

  task automatic assert_reset();
    rst = 1'b1;
    #2;
    model_reset();
  endtask

  // Runs 300 cycles after a release, counting busy cycles and reads seen while busy.
  task automatic run_clear(input bit noisy, output int ba, output int bb, output int sa, output int sb);
    ba = 0; bb = 0; sa = 0; sb = 0;
    for (int k = 0; k < 300; k++) begin
      if (noisy && k < 150) begin
        wr_en = 1'($urandom); rd_en = 1'($urandom);
        wr_addr = 8'($urandom); rd_addr = 8'($urandom);
        wr_data = 16'($urandom); wr_be = 2'($urandom);
      end else idle();
      if (init_busy_a) ba++;
      if (init_busy_b) bb++;
      if (rd_valid_a && init_busy_a) sa++;
      if (rd_valid_b && init_busy_b) sb++;
      tick();
    end
    idle();
  endtask

  task automatic test_reset();
    int ba, bb, sa, sb;
    logic [7:0] a;
    assert_reset();
    for (int d = 0; d < 2; d++) begin
      tests_run++;
      if (dut_valid(d) !== 1'b0 || dut_data(d) !== 16'h0 || dut_busy(d) !== 1'b1) begin
        fails++;
        $display("[TB] FAIL reset_state dut%0d: valid=%b data=%h busy=%b, expected 0/0000/1",
                 d, dut_valid(d), dut_data(d), dut_busy(d));
      end
    end
    tick();
    rst = 1'b0;
    run_clear(1'b1, ba, bb, sa, sb);
    tests_run++;
    if (ba != 256) begin fails++; $display("[TB] FAIL clear_len_a: busy %0d cycles, expected 256", ba); end
    tests_run++;
    if (bb != 200) begin fails++; $display("[TB] FAIL clear_len_b: busy %0d cycles, expected 200", bb); end
    tests_run++;
    if (sa != 0 || sb != 0) begin
      fails++; $display("[TB] FAIL clear_no_read: valid during clear a=%0d b=%0d, expected 0", sa, sb);
    end
    for (int n = 0; n < 3; n++) begin
      a = 8'($urandom_range(0, 199));
      set_read(a); tick(); idle();
      tests_run++;
      if (rd_valid_a !== 1'b1 || rd_data_a !== 16'h0) begin
        fails++; $display("[TB] FAIL cleared_read_a @%h: valid=%b data=%h, expected 1/0000", a, rd_valid_a, rd_data_a);
      end
      tick();
      tests_run++;
      if (rd_valid_b !== 1'b1 || rd_data_b !== 16'h0) begin
        fails++; $display("[TB] FAIL cleared_read_b @%h: valid=%b data=%h, expected 1/0000", a, rd_valid_b, rd_data_b);
      end
    end
  endtask

  task automatic test_write_read();
    set_write(8'h10, 16'h00A5, 2'b11); tick(); idle();
    set_read(8'h10); tick(); idle();
    tests_run++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 16'h00A5 || rd_valid_b !== 1'b0) begin
      fails++; $display("[TB] FAIL wr_rd_lat1: a valid=%b data=%h b valid=%b, expected 1/00a5 and 0",
                        rd_valid_a, rd_data_a, rd_valid_b);
    end
    tick();
    tests_run++;
    if (rd_valid_b !== 1'b1 || rd_data_b !== 16'h00A5 || rd_valid_a !== 1'b0 || rd_data_a !== 16'h00A5) begin
      fails++; $display("[TB] FAIL wr_rd_lat2: b valid=%b data=%h a valid=%b data=%h, expected 1/00a5 0/00a5",
                        rd_valid_b, rd_data_b, rd_valid_a, rd_data_a);
    end
  endtask

  task automatic test_byte_enable();
    set_write(8'd3, 16'h1234, 2'b11); tick();
    set_write(8'd3, 16'hABCD, 2'b10); tick();
    set_write(8'd3, 16'hFFFF, 2'b00); tick(); idle();
    set_read(8'd3); tick(); idle();
    tests_run++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 16'hAB34) begin
      fails++; $display("[TB] FAIL byte_en_a: valid=%b data=%h, expected 1/ab34", rd_valid_a, rd_data_a);
    end
    tick();
    tests_run++;
    if (rd_valid_b !== 1'b1 || rd_data_b !== 16'hAB34) begin
      fails++; $display("[TB] FAIL byte_en_b: valid=%b data=%h, expected 1/ab34", rd_valid_b, rd_data_b);
    end
  endtask

  task automatic test_rdw();
    set_write(8'd5, 16'h0011, 2'b11); tick();
    set_write(8'd5, 16'h0022, 2'b11); set_read(8'd5); tick();
    wr_en = 1'b0;
    tests_run++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 16'h0011) begin
      fails++; $display("[TB] FAIL rdw_old_a: valid=%b data=%h, expected 1/0011", rd_valid_a, rd_data_a);
    end
    tick(); idle();
    tests_run++;
    if (rd_data_a !== 16'h0022 || rd_valid_b !== 1'b1 || rd_data_b !== 16'h0022) begin
      fails++; $display("[TB] FAIL rdw_new_b: a data=%h b valid=%b data=%h, expected 0022 1/0022",
                        rd_data_a, rd_valid_b, rd_data_b);
    end
    tick();
    tests_run++;
    if (rd_valid_b !== 1'b1 || rd_data_b !== 16'h0022 || rd_valid_a !== 1'b0) begin
      fails++; $display("[TB] FAIL rdw_follow_b: b valid=%b data=%h a valid=%b, expected 1/0022 0",
                        rd_valid_b, rd_data_b, rd_valid_a);
    end
    set_write(8'd6, 16'h3344, 2'b11); tick();
    set_write(8'd6, 16'hAABB, 2'b01); set_read(8'd6); tick(); idle();
    tests_run++;
    if (rd_data_a !== 16'h3344) begin
      fails++; $display("[TB] FAIL rdw_partial_a: data=%h, expected 3344", rd_data_a);
    end
    tick();
    tests_run++;
    if (rd_valid_b !== 1'b1 || rd_data_b !== 16'h33BB) begin
      fails++; $display("[TB] FAIL rdw_partial_b: valid=%b data=%h, expected 1/33bb", rd_valid_b, rd_data_b);
    end
  endtask

  task automatic test_out_of_range();
    set_write(8'd250, 16'h0077, 2'b11); tick();
    set_write(8'd199, 16'h5A5A, 2'b11); tick();
    set_write(8'd200, 16'h0066, 2'b11); tick(); idle();
    set_read(8'd250); tick();
    tests_run++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 16'h0077) begin
      fails++; $display("[TB] FAIL oor_a250: valid=%b data=%h, expected 1/0077", rd_valid_a, rd_data_a);
    end
    set_read(8'd199); tick();
    tests_run++;
    if (rd_data_a !== 16'h5A5A || rd_valid_b !== 1'b1 || rd_data_b !== 16'h0000) begin
      fails++; $display("[TB] FAIL oor_b250: a data=%h b valid=%b data=%h, expected 5a5a 1/0000",
                        rd_data_a, rd_valid_b, rd_data_b);
    end
    set_read(8'd200); tick(); idle();
    tests_run++;
    if (rd_data_a !== 16'h0066 || rd_data_b !== 16'h5A5A) begin
      fails++; $display("[TB] FAIL oor_edge199: a data=%h b data=%h, expected 0066 5a5a", rd_data_a, rd_data_b);
    end
    tick();
    tests_run++;
    if (rd_valid_b !== 1'b1 || rd_data_b !== 16'h0000) begin
      fails++; $display("[TB] FAIL oor_b200: valid=%b data=%h, expected 1/0000", rd_valid_b, rd_data_b);
    end
  endtask

  // Sweeps every address one read per cycle, comparing each cycle to the model.
  task automatic test_back_to_back();
    int pulses_a;
    pulses_a = 0;
    for (int k = 0; k < 258; k++) begin
      if (k < 256) set_read(8'(k)); else idle();
      tick();
      if (rd_valid_a) pulses_a++;
      for (int d = 0; d < 2; d++) begin
        tests_run++;
        if (dut_valid(d) !== exp_v[d][0] || dut_data(d) !== exp_hold[d]) begin
          fails++; $display("[TB] FAIL b2b dut%0d cyc %0d: valid=%b data=%h, expected %b/%h",
                            d, cyc, dut_valid(d), dut_data(d), exp_v[d][0], exp_hold[d]);
        end
      end
    end
    tests_run++;
    if (pulses_a != 256) begin fails++; $display("[TB] FAIL b2b_pulses_a: %0d pulses, expected 256", pulses_a); end
  endtask

  task automatic test_reset_mid_clear();
    int ba, bb, sa, sb;
    assert_reset(); tick(); rst = 1'b0;
    for (int k = 0; k < 100; k++) tick();
    assert_reset();
    tests_run++;
    if (init_busy_a !== 1'b1 || init_busy_b !== 1'b1) begin
      fails++; $display("[TB] FAIL midclear_busy: a=%b b=%b, expected 1/1", init_busy_a, init_busy_b);
    end
    tick(); rst = 1'b0;
    run_clear(1'b0, ba, bb, sa, sb);
    tests_run++;
    if (ba != 256 || bb != 200) begin
      fails++; $display("[TB] FAIL midclear_len: a=%0d b=%0d busy cycles, expected 256/200", ba, bb);
    end
  endtask

  task automatic test_reset_mid_read();
    int ba, bb, sa, sb;
    set_write(8'd7, 16'h0BEE, 2'b11); tick(); idle();
    set_read(8'd7); tick(); idle();
    assert_reset();
    tests_run++;
    if (rd_valid_b !== 1'b0 || rd_data_b !== 16'h0 || rd_data_a !== 16'h0) begin
      fails++; $display("[TB] FAIL midread_async: b valid=%b data=%h a data=%h, expected 0/0000 0000",
                        rd_valid_b, rd_data_b, rd_data_a);
    end
    tick();
    tests_run++;
    if (rd_valid_b !== 1'b0) begin fails++; $display("[TB] FAIL midread_drop: b valid=%b, expected 0", rd_valid_b); end
    rst = 1'b0;
    run_clear(1'b0, ba, bb, sa, sb);
    tests_run++;
    if (sb != 0 || ba != 256) begin
      fails++; $display("[TB] FAIL midread_clear: b spurious=%0d a busy=%0d, expected 0/256", sb, ba);
    end
    set_read(8'd7); tick(); idle();
    tests_run++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 16'h0) begin
      fails++; $display("[TB] FAIL midread_zeroed: a valid=%b data=%h, expected 1/0000", rd_valid_a, rd_data_a);
    end
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      wr_en = 1'($urandom); rd_en = 1'($urandom);
      wr_addr = rand_addr();
      rd_addr = ($urandom_range(0, 2) == 0) ? wr_addr : rand_addr();
      wr_data = 16'($urandom); wr_be = 2'($urandom);
      tick();
      for (int d = 0; d < 2; d++) begin
        tests_run++;
        if (dut_valid(d) !== exp_v[d][0] || dut_data(d) !== exp_hold[d] || dut_busy(d) !== (clr_left[d] != 0)) begin
          fails++; $display("[TB] FAIL random dut%0d cyc %0d: valid=%b data=%h busy=%b, expected %b/%h/%b",
                            d, cyc, dut_valid(d), dut_data(d), dut_busy(d), exp_v[d][0], exp_hold[d], clr_left[d] != 0);
        end
      end
    end
    idle();
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    model_reset();
    test_reset();
    test_write_read();
    test_byte_enable();
    test_rdw();
    test_out_of_range();
    test_back_to_back();
    test_random();
    test_reset_mid_clear();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
